traffic_light_monitor: RTL and testbench

- Independent checker on the receiving end of the traffic-light LED bus. It samples the 16-bit light pattern that the light sequencer drives and decodes it back into a phase number.
- Checks three things: the pattern is legal, the phase order is legal, and each phase's dwell time is within limits.
- Reports the decoded phase, a lock flag, a sticky fault with a code, and a count of completed rotations.
- Sits beside the sequencer on the board top level and is used both on hardware and as a bench checker.

---
 rtl/traffic_light_if.sv | 8 +
 rtl/traffic_light_monitor.sv | 146 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/traffic_light_if.sv
// LED bus between the light sequencer (master) and any listener (slave).
//   lights : 16-bit LED pattern driven by the sequencer
interface traffic_light_if;
  logic [15:0] lights;

  modport master (output lights);
  modport slave  (input  lights);
endinterface

// File: rtl/traffic_light_monitor.sv
// Independent checker for the traffic-light LED bus. Decodes the sampled
// pattern back to a phase and checks pattern legality, phase order and
// per-phase dwell time.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus.lights  : LED pattern from the sequencer
//   clr_btn     : raw asynchronous fault-clear pushbutton
//   phase       : decoded current phase
//   locked      : tracking a legal sequence
//   fault       : sticky fault flag
//   fault_code  : cause of the first fault (1 illegal, 2 sequence, 3 short, 4 stuck)
//   rotations   : count of completed 3->0 wraps
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL = 32'd499_000_000,
  parameter int unsigned MAX_DWELL = 32'd501_000_000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  traffic_light_if.slave      bus,
  input  logic                clr_btn,
  output logic [1:0]          phase,
  output logic                locked,
  output logic                fault,
  output logic [2:0]          fault_code,
  output logic [15:0]         rotations
);

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] MAX_M1_C = CNT_W'(MAX_DWELL - 32'd1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_SEQ     = 3'd2;
  localparam logic [2:0] FC_SHORT   = 3'd3;
  localparam logic [2:0] FC_STUCK   = 3'd4;

  typedef enum logic [1:0] {S_SYNC, S_TRACK, S_FAULT} state_t;
  typedef enum logic [1:0] {PAT_LEGAL, PAT_DARK, PAT_ILLEGAL} pat_t;

  state_t           state;
  logic [15:0]      lights_q;
  logic [CNT_W-1:0] dwell_cnt;
  logic             first_dwell;
  logic             clr_s1, clr_s2, clr_s3;
  logic             clr_pulse;

  pat_t             pat_kind;
  logic [1:0]       pat_phase;
  logic [2:0]       track_code;

  // Pattern decode from the registered bus sample
  always_comb begin
    pat_kind  = PAT_ILLEGAL;
    pat_phase = 2'd0;
    case (lights_q)
      16'hC0C0: begin pat_kind = PAT_LEGAL; pat_phase = 2'd0; end
      16'h2020: begin pat_kind = PAT_LEGAL; pat_phase = 2'd1; end
      16'h0E00: begin pat_kind = PAT_LEGAL; pat_phase = 2'd2; end
      16'h000E: begin pat_kind = PAT_LEGAL; pat_phase = 2'd3; end
      16'h0000: pat_kind = PAT_DARK;
      default:  pat_kind = PAT_ILLEGAL;
    endcase
  end

  // Violation check while tracking; the if-chain order gives priority 1>2>3>4.
  // Stuck fires on the edge where the counter would reach MAX_DWELL.
  always_comb begin
    track_code = FC_NONE;
    if (pat_kind != PAT_LEGAL) begin
      track_code = FC_ILLEGAL;
    end else if (pat_phase == phase) begin
      if (dwell_cnt >= MAX_M1_C) track_code = FC_STUCK;
    end else if (pat_phase != phase + 2'd1) begin
      track_code = FC_SEQ;
    end else if (!first_dwell && (dwell_cnt < MIN_C)) begin
      track_code = FC_SHORT;
    end
  end

  // Input capture, clear synchroniser and monitor FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_SYNC;
      lights_q    <= 16'h0000;
      dwell_cnt   <= '0;
      first_dwell <= 1'b1;
      clr_s1      <= 1'b0;
      clr_s2      <= 1'b0;
      clr_s3      <= 1'b0;
      clr_pulse   <= 1'b0;
      phase       <= 2'd0;
      locked      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      rotations   <= 16'd0;
    end else begin
      lights_q  <= bus.lights;
      clr_s1    <= clr_btn;
      clr_s2    <= clr_s1;
      clr_s3    <= clr_s2;
      clr_pulse <= clr_s2 & ~clr_s3;

      case (state)
        S_SYNC: begin
          if (pat_kind == PAT_LEGAL) begin
            phase       <= pat_phase;
            locked      <= 1'b1;
            dwell_cnt   <= ONE_C;
            first_dwell <= 1'b1;
            state       <= S_TRACK;
          end
        end

        S_TRACK: begin
          if (track_code != FC_NONE) begin
            fault      <= 1'b1;
            fault_code <= track_code;
            locked     <= 1'b0;
            state      <= S_FAULT;
            if (track_code == FC_STUCK) dwell_cnt <= MAX_C;
          end else if (pat_phase == phase) begin
            if (dwell_cnt < MAX_C) dwell_cnt <= dwell_cnt + ONE_C;
          end else begin
            phase       <= pat_phase;
            dwell_cnt   <= ONE_C;
            first_dwell <= 1'b0;
            if (phase == 2'd3) rotations <= rotations + 16'd1;
          end
        end

        S_FAULT: begin
          if (clr_pulse) begin
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            state      <= S_SYNC;
          end
        end

        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with MIN_DWELL=8, MAX_DWELL=12.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_btn;
  logic [1:0]  phase;
  logic        locked;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] rotations;

  int checks = 0;
  int errors = 0;

  traffic_light_if bus ();

  traffic_light_monitor #(
    .MIN_DWELL (8),
    .MAX_DWELL (12),
    .CNT_W     (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .clr_btn    (clr_btn),
    .phase      (phase),
    .locked     (locked),
    .fault      (fault),
    .fault_code (fault_code),
    .rotations  (rotations)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lights;
    logic        clr;
    int          n;
    logic [1:0]  ph;
    logic        lk;
    logic        f;
    logic [2:0]  fc;
    logic [15:0] rot;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h want %0h", name, field, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] ep, input logic el,
                            input logic ef, input logic [2:0] ec, input logic [15:0] er);
    cmp(name, "phase",      32'(phase),      32'(ep));
    cmp(name, "locked",     32'(locked),     32'(el));
    cmp(name, "fault",      32'(fault),      32'(ef));
    cmp(name, "fault_code", 32'(fault_code), 32'(ec));
    cmp(name, "rotations",  32'(rotations),  32'(er));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    clr_btn    = 1'b0;
    bus.lights = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic hold(input logic [15:0] pat, input int n);
    bus.lights = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic rotate_once();
    hold(16'h2020, 10);
    hold(16'h0E00, 10);
    hold(16'h000E, 10);
    hold(16'hC0C0, 10);
  endtask

  initial begin
    int cnt;

    // lights, clr, cycles, phase, locked, fault, code, rotations
    vecs.push_back('{16'hC0C0, 1'b0, 1,  2'd0, 1'b0, 1'b0, 3'd0, 16'd0}); // captured, not yet locked
    vecs.push_back('{16'hC0C0, 1'b0, 1,  2'd0, 1'b1, 1'b0, 3'd0, 16'd0}); // locked 2 cycles after
    vecs.push_back('{16'hC0C0, 1'b0, 8,  2'd0, 1'b1, 1'b0, 3'd0, 16'd0});
    vecs.push_back('{16'h2020, 1'b0, 1,  2'd0, 1'b1, 1'b0, 3'd0, 16'd0}); // 2-cycle latency
    vecs.push_back('{16'h2020, 1'b0, 1,  2'd1, 1'b1, 1'b0, 3'd0, 16'd0});
    vecs.push_back('{16'h2020, 1'b0, 8,  2'd1, 1'b1, 1'b0, 3'd0, 16'd0});
    vecs.push_back('{16'h0E00, 1'b0, 2,  2'd2, 1'b1, 1'b0, 3'd0, 16'd0});
    vecs.push_back('{16'h0E00, 1'b0, 8,  2'd2, 1'b1, 1'b0, 3'd0, 16'd0});
    vecs.push_back('{16'h000E, 1'b0, 2,  2'd3, 1'b1, 1'b0, 3'd0, 16'd0});
    vecs.push_back('{16'h000E, 1'b0, 8,  2'd3, 1'b1, 1'b0, 3'd0, 16'd0});
    vecs.push_back('{16'hC0C0, 1'b0, 2,  2'd0, 1'b1, 1'b0, 3'd0, 16'd1}); // wrap counted
    vecs.push_back('{16'hC0C0, 1'b0, 8,  2'd0, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h2020, 1'b0, 10, 2'd1, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h2021, 1'b0, 1,  2'd1, 1'b1, 1'b0, 3'd0, 16'd1}); // glitch
    vecs.push_back('{16'h2020, 1'b0, 1,  2'd1, 1'b0, 1'b1, 3'd1, 16'd1}); // illegal
    vecs.push_back('{16'h2020, 1'b0, 5,  2'd1, 1'b0, 1'b1, 3'd1, 16'd1}); // sticky
    vecs.push_back('{16'h2020, 1'b1, 3,  2'd1, 1'b0, 1'b1, 3'd1, 16'd1}); // clear in flight
    vecs.push_back('{16'h2020, 1'b1, 1,  2'd1, 1'b0, 1'b0, 3'd0, 16'd1}); // cleared at 4
    vecs.push_back('{16'h2020, 1'b0, 1,  2'd1, 1'b1, 1'b0, 3'd0, 16'd1}); // relock
    vecs.push_back('{16'h2020, 1'b0, 10, 2'd1, 1'b1, 1'b0, 3'd0, 16'd1}); // dwell 11
    vecs.push_back('{16'h2020, 1'b0, 1,  2'd1, 1'b0, 1'b1, 3'd4, 16'd1}); // stuck
    vecs.push_back('{16'h0000, 1'b1, 4,  2'd1, 1'b0, 1'b0, 3'd0, 16'd1}); // clear
    vecs.push_back('{16'hC0C0, 1'b0, 2,  2'd0, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'hC0C0, 1'b0, 8,  2'd0, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h0E00, 1'b0, 2,  2'd0, 1'b0, 1'b1, 3'd2, 16'd1}); // skip
    vecs.push_back('{16'h0000, 1'b1, 4,  2'd0, 1'b0, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h2020, 1'b0, 2,  2'd1, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h2020, 1'b0, 8,  2'd1, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h0E00, 1'b0, 5,  2'd2, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h000E, 1'b0, 1,  2'd2, 1'b1, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h000E, 1'b0, 1,  2'd2, 1'b0, 1'b1, 3'd3, 16'd1}); // short dwell
    vecs.push_back('{16'h0000, 1'b1, 4,  2'd2, 1'b0, 1'b0, 3'd0, 16'd1});
    vecs.push_back('{16'h2020, 1'b0, 3,  2'd1, 1'b1, 1'b0, 3'd0, 16'd1}); // short first dwell
    vecs.push_back('{16'h0E00, 1'b1, 2,  2'd2, 1'b1, 1'b0, 3'd0, 16'd1}); // exempt
    vecs.push_back('{16'h0E00, 1'b1, 2,  2'd2, 1'b1, 1'b0, 3'd0, 16'd1}); // clr ignored
    vecs.push_back('{16'h2020, 1'b0, 2,  2'd2, 1'b0, 1'b1, 3'd2, 16'd1}); // seq beats short

    do_reset();
    check_outs("reset", 2'd0, 1'b0, 1'b0, 3'd0, 16'd0);

    foreach (vecs[i]) begin
      bus.lights = vecs[i].lights;
      clr_btn    = vecs[i].clr;
      repeat (vecs[i].n) @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].ph, vecs[i].lk, vecs[i].f,
                 vecs[i].fc, vecs[i].rot);
    end
    clr_btn = 1'b0;

    // Stuck from reset: fault appears exactly 13 edges after 2020 is shown
    do_reset();
    bus.lights = 16'h2020;
    cnt = 0;
    while (!fault && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    cmp("stuck_latency", "cycles", 32'(cnt), 32'd13);
    check_outs("stuck", 2'd1, 1'b0, 1'b1, 3'd4, 16'd0);

    // Bad sequence and short dwell together after a non-first dwell of 3
    do_reset();
    hold(16'hC0C0, 10);
    hold(16'h2020, 10);
    hold(16'h0E00, 10);
    hold(16'h000E, 10);
    hold(16'hC0C0, 3);
    check_outs("pre_jump", 2'd0, 1'b1, 1'b0, 3'd0, 16'd1);
    hold(16'h0E00, 2);
    check_outs("simul", 2'd0, 1'b0, 1'b1, 3'd2, 16'd1);

    // Reset mid-operation with rotations=3
    do_reset();
    hold(16'hC0C0, 10);
    rotate_once();
    rotate_once();
    rotate_once();
    check_outs("pre_rst", 2'd0, 1'b1, 1'b0, 3'd0, 16'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_outs("mid_rst", 2'd0, 1'b0, 1'b0, 3'd0, 16'd0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
